// File: rtl/step2_if.sv
// Bus bundle between step2 and its neighbours: start pulse, projected vectors,
// belief/reward inputs, and the per-action backup results.
interface step2_if #(
  parameter int unsigned NUM_ALPHA = 16
);
  localparam int unsigned IW = $clog2(NUM_ALPHA);

  logic          en;
  logic [15:0]   gamma_in [0:2][0:1][0:NUM_ALPHA-1][0:1];
  logic [15:0]   belief   [0:1];
  logic [15:0]   reward   [0:2][0:1];
  logic          busy;
  logic [IW-1:0] best_idx [0:2][0:1];
  logic [15:0]   gamma_action_belief [0:2][0:1];
  logic          en_step3;

  modport master (
    output en, gamma_in, belief, reward,
    input  busy, best_idx, gamma_action_belief, en_step3
  );

  modport slave (
    input  en, gamma_in, belief, reward,
    output busy, best_idx, gamma_action_belief, en_step3
  );
endinterface

// File: rtl/step2.sv
// PBVI point-based backup: per (action, obs) argmax of belief . alpha, then
// per-action sum of winners plus reward with 16-bit saturation.
module step2 #(
  parameter int unsigned NUM_ALPHA = 16
) (
  input  logic    clk,
  input  logic    rst_n,
  step2_if.slave  bus
);
  localparam int unsigned IW = $clog2(NUM_ALPHA);
  localparam int unsigned DW = 16;
  localparam int unsigned PW = 33;
  localparam int unsigned SW = 18;

  typedef enum logic [1:0] {IDLE, SCAN, SUM, DONE} state_t;

  state_t        state, state_d;
  logic [IW-1:0] j;
  logic [DW-1:0] belief_q [0:1];
  logic [DW-1:0] reward_q [0:2][0:1];
  logic [PW-1:0] best_val [0:2][0:1];
  logic [IW-1:0] best_idx [0:2][0:1];
  logic [DW-1:0] gab      [0:2][0:1];
  logic          busy, en_step3;
  logic          busy_d, done_d, last_j;

  logic [PW-1:0] dot    [0:2][0:1];
  logic [SW-1:0] sum18  [0:2][0:1];
  logic [DW-1:0] gab_d  [0:2][0:1];

  assign last_j = (j == IW'(NUM_ALPHA - 1));

  // Next-state and registered-output decode; a start pulse overrides everything.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    state_d = IDLE;
      SCAN:    if (last_j) state_d = SUM;
      SUM:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.en) state_d = SCAN;
    busy_d = (state_d == SCAN) || (state_d == SUM);
    done_d = (state_d == DONE);
  end

  // Dot products for the current scan index and saturated per-action sums.
  always_comb begin
    for (int a = 0; a < 3; a++) begin
      for (int o = 0; o < 2; o++) begin
        dot[a][o] = PW'(belief_q[0]) * PW'(bus.gamma_in[a][o][j][0])
                  + PW'(belief_q[1]) * PW'(bus.gamma_in[a][o][j][1]);
      end
      for (int s = 0; s < 2; s++) begin
        sum18[a][s] = SW'(reward_q[a][s])
                    + SW'(bus.gamma_in[a][0][best_idx[a][0]][s])
                    + SW'(bus.gamma_in[a][1][best_idx[a][1]][s]);
        gab_d[a][s] = (sum18[a][s][SW-1:DW] != 2'b00) ? {DW{1'b1}} : sum18[a][s][DW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      j        <= '0;
      busy     <= 1'b0;
      en_step3 <= 1'b0;
      for (int s = 0; s < 2; s++) belief_q[s] <= '0;
      for (int a = 0; a < 3; a++) begin
        for (int k = 0; k < 2; k++) begin
          reward_q[a][k] <= '0;
          best_val[a][k] <= '0;
          best_idx[a][k] <= '0;
          gab[a][k]      <= '0;
        end
      end
    end else begin
      state    <= state_d;
      busy     <= busy_d;
      en_step3 <= done_d;
      if (bus.en) begin
        j <= '0;
        for (int s = 0; s < 2; s++) belief_q[s] <= bus.belief[s];
        for (int a = 0; a < 3; a++) begin
          for (int k = 0; k < 2; k++) begin
            reward_q[a][k] <= bus.reward[a][k];
            best_val[a][k] <= '0;
            best_idx[a][k] <= '0;
          end
        end
      end else if (state == SCAN) begin
        j <= last_j ? '0 : j + IW'(1);
        // Strict compare keeps the lowest index on ties.
        for (int a = 0; a < 3; a++) begin
          for (int o = 0; o < 2; o++) begin
            if ((j == '0) || (dot[a][o] > best_val[a][o])) begin
              best_val[a][o] <= dot[a][o];
              best_idx[a][o] <= j;
            end
          end
        end
      end else if (state == SUM) begin
        for (int a = 0; a < 3; a++) begin
          for (int s = 0; s < 2; s++) gab[a][s] <= gab_d[a][s];
        end
      end
    end
  end

  assign bus.busy                = busy;
  assign bus.en_step3            = en_step3;
  assign bus.best_idx            = best_idx;
  assign bus.gamma_action_belief = gab;

endmodule

// File: doc/step2.md
# step2

Point-based backup stage of the PBVI value-iteration pipeline, directly downstream of `step1`. For one belief point it scans the 16 projected alpha vectors of every (action, observation) pair and picks the one with the largest dot product with the belief. It then sums the winners over observations and adds the per-action reward, producing one back-projected alpha vector per action. Completion is signalled to the next stage with a single-cycle `en_step3` pulse.

## Interface
Parameters:
- `NUM_ALPHA`, default 16: alpha vectors scanned per (a,o) pair; the index width is `$clog2(NUM_ALPHA)`.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  start pulse; this is `step1`'s `en_step2`.
- `gamma_in [0:2][0:1][0:NUM_ALPHA-1][0:1]`  in  16 each  projected vectors `[action][obs][alpha][state]`, unsigned Q0.16.
- `belief [0:1]`  in  16 each  belief point, Q0.16; sampled when `en` is seen.
- `reward [0:2][0:1]`  in  16 each  reward `[action][state]`, Q0.16; sampled when `en` is seen.
- `busy`  out  1  high in states SCAN and SUM.
- `best_idx [0:2][0:1]`  out  4 each  winning alpha index per (a,o).
- `gamma_action_belief [0:2][0:1]`  out  16 each  back-projected vector per action and state.
- `en_step3`  out  1  one-cycle done pulse.

## Operation
- States: IDLE, SCAN, SUM, DONE.
- On any rising edge with `en`=1, in any state:
  - latch `belief` and `reward`;
  - clear all six best-value registers to 0 and all `best_idx` to 0;
  - set scan counter `j`=0 and go to SCAN.
- `en` always wins; a new `en` aborts the current job without emitting a pulse for it.
- SCAN, one edge per `j`, all six (a,o) pairs in parallel:
  - `dot = belief[0]*gamma_in[a][o][j][0] + belief[1]*gamma_in[a][o][j][1]`, kept at full 33-bit width.
  - If `j`==0 or `dot` > stored best (strict), store `dot` and set `best_idx[a][o]`=`j`.
  - Ties keep the lowest index.
  - `j` increments; after processing `j`=NUM_ALPHA-1, go to SUM.
- SUM, one edge:
  - `gamma_action_belief[a][s] = sat16(reward[a][s] + gamma_in[a][0][best_idx[a][0]][s] + gamma_in[a][1][best_idx[a][1]][s])`.
  - Addition is done at 18 bits; a result above 0xFFFF clamps to 0xFFFF.
  - Go to DONE.
- DONE: `en_step3`=1 for exactly this cycle, then IDLE.
- Outputs hold their values until the next SUM or reset.
- `gamma_in` is not latched. Upstream holds it stable from the `en` edge through the SUM edge.

## Timing
- Reset values: IDLE, `busy`=0, `en_step3`=0, all `best_idx`=0, all `gamma_action_belief`=0, `j`=0, best values 0.
- `en` is sampled at edge E0. Edges E1..E16 process `j`=0..15. Edge E17 performs SUM.
- `en_step3` is high during the cycle after E17, i.e. 17 cycles after E0. This matches the gap between an `en` edge and the corresponding `en_step3` pulse in test 5.
- `best_idx` and `gamma_action_belief` are valid, and `busy`=0, in the same cycle `en_step3`=1.
- `en` during DONE restarts; `en_step3` still completes that cycle.
- Back-to-back jobs: minimum spacing is 18 cycles from one `en` to the next.
- Reset asserted mid-operation: immediate return to reset values; no `en_step3` for the aborted job.
- `en` held high for several cycles: every held edge restarts, so the scan begins after `en` falls.

## Test plan
1. Single winner:
   - stimulus: `belief`=(0x8000,0x8000), `reward`=0; all gamma 0 except `gamma_in[*][*][5]`=(0x1000,0x1000).
   - required: `best_idx` all 5; `gamma_action_belief` all 0x2000; `en_step3` exactly 17 cycles after the `en` edge.
2. Ties:
   - stimulus: every gamma = (0x0100,0x0100).
   - required: `best_idx` all 0; outputs = `reward` + 0x0200.
3. Belief weighting:
   - stimulus: `belief`=(0xFFFF,0); `gamma_in[*][*][3]`=(0x4000,0); `gamma_in[*][*][9]`=(0x3000,0xFFFF); rest 0.
   - required: `best_idx` all 3.
4. Saturation:
   - stimulus: `reward`=0xFFFF; all gamma (0x8000,0x8000).
   - required: all outputs 0xFFFF.
5. Restart:
   - stimulus: second `en` while SCAN is at `j`=7.
   - required: exactly one `en_step3`, 17 cycles after the second `en` edge, with results from the second job's data.
6. Reset mid-operation:
   - stimulus: `rst_n` low at `j`=10.
   - required: `busy`=0 and outputs 0 immediately; no `en_step3` follows.
